// File: rtl/axi_read_ctrl.sv
// axi_read_ctrl: AR/R channel controller for the 2-master / 5-slave interconnect.
// Arbitrates AR between M0 (ifetch) and M1 (data), decodes the target slave,
// sequences address and data phases, and serves DECERR for unmapped reads.
module axi_read_ctrl #(
  parameter int ID_BITS  = 4,
  parameter int IDS_BITS = 8
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                ARVALID_M0,
  input  logic                ARVALID_M1,
  input  logic [31:0]         ARADDR_M0,
  input  logic [31:0]         ARADDR_M1,
  input  logic [ID_BITS-1:0]  ARID_M0,
  input  logic [ID_BITS-1:0]  ARID_M1,
  input  logic                RREADY_M0,
  input  logic                RREADY_M1,
  input  logic                ARREADY,
  input  logic                RVALID,
  input  logic                RLAST,
  output logic [4:0]          CS_R,
  output logic [4:0]          NS_R,
  output logic                ARREADY_def,
  output logic                RVALID_def,
  output logic                RLAST_def,
  output logic [IDS_BITS-1:0] RID_def,
  output logic [1:0]          RRESP_default
);

  // Encoding is shared with the S2M mux; do not renumber.
  localparam logic [4:0] IDLE    = 5'd0;
  localparam logic [4:0] RA_M1   = 5'd1;
  localparam logic [4:0] RD_M1S0 = 5'd2;
  localparam logic [4:0] RD_M1S4 = 5'd6;
  localparam logic [4:0] RA_M0   = 5'd7;
  localparam logic [4:0] RD_M0S0 = 5'd8;
  localparam logic [4:0] RD_M0S4 = 5'd12;
  localparam logic [4:0] DEF_SLV = 5'd25;

  logic        last_grant;  // 1 = M1 granted last
  logic        owner;       // 1 = M1 owns the current transaction
  logic        sel_m0;
  logic        in_addr;
  logic        rd_m0;
  logic        rd_m1;
  logic        gnt_m1;
  logic        hit;
  logic [2:0]  slv;
  logic [15:0] addr_hi;
  logic        unused_lo;

  // Only the upper half of the address participates in decode.
  assign unused_lo = ^{ARADDR_M0[15:0], ARADDR_M1[15:0]};

  assign sel_m0  = (CS_R == RA_M0);
  assign in_addr = (CS_R == RA_M0) || (CS_R == RA_M1);
  assign rd_m0   = (CS_R >= RD_M0S0) && (CS_R <= RD_M0S4);
  assign rd_m1   = (CS_R >= RD_M1S0) && (CS_R <= RD_M1S4);
  assign addr_hi = sel_m0 ? ARADDR_M0[31:16] : ARADDR_M1[31:16];

  // On a tie the master not granted last wins.
  assign gnt_m1 = ARVALID_M1 && (!ARVALID_M0 || !last_grant);

  // Slave decode of the owning master's address.
  always_comb begin
    hit = 1'b1;
    slv = 3'd0;
    if      (addr_hi == 16'h0000)      slv = 3'd0;
    else if (addr_hi == 16'h0001)      slv = 3'd1;
    else if (addr_hi == 16'h0002)      slv = 3'd2;
    else if (addr_hi == 16'h1000)      slv = 3'd3;
    else if (addr_hi[15:8] == 8'h20)   slv = 3'd4;
    else                               hit = 1'b0;
  end

  // Next-state logic; illegal codes fall back to IDLE.
  always_comb begin
    NS_R = IDLE;
    if (CS_R == IDLE) begin
      if (gnt_m1)          NS_R = RA_M1;
      else if (ARVALID_M0) NS_R = RA_M0;
    end else if (in_addr) begin
      if (!hit)            NS_R = DEF_SLV;
      else if (ARREADY)    NS_R = (sel_m0 ? RD_M0S0 : RD_M1S0) + {2'b00, slv};
      else                 NS_R = CS_R;
    end else if (rd_m0 || rd_m1) begin
      if (RVALID && RLAST && (rd_m0 ? RREADY_M0 : RREADY_M1)) NS_R = IDLE;
      else                                                    NS_R = CS_R;
    end else if (CS_R == DEF_SLV) begin
      NS_R = (owner ? RREADY_M1 : RREADY_M0) ? IDLE : DEF_SLV;
    end
    if (!ARESETn) NS_R = IDLE;
  end

  // Default slave: accept unmapped AR immediately, return one DECERR beat.
  assign ARREADY_def   = in_addr && !hit;
  assign RVALID_def    = (CS_R == DEF_SLV);
  assign RLAST_def     = (CS_R == DEF_SLV);
  assign RRESP_default = 2'b11;

  // State, grant history, owner and default-slave RID registers.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      CS_R       <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      RID_def    <= '0;
    end else begin
      CS_R <= NS_R;
      if (CS_R == IDLE && NS_R != IDLE) begin
        last_grant <= gnt_m1;
        owner      <= gnt_m1;
      end
      if (ARREADY_def)
        RID_def <= sel_m0 ? IDS_BITS'({4'b0001, ARID_M0}) : IDS_BITS'({4'b0010, ARID_M1});
    end
  end

endmodule
